// File: rtl/tof_pkg.sv
// Shared types and constants for the time-of-flight shot sequencer.
package tof_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRE    = 3'd1,
    WAIT    = 3'd2,
    HIT     = 3'd3,
    MISS    = 3'd4,
    HOLDOFF = 3'd5,
    DONE    = 3'd6
  } tof_state_t;

  // Width of the clamped thermometer fine code.
  localparam int FINE_W = 3;

  // A shot time is the coarse cycle count with the fine code appended below it.
  function automatic int shot_time_w(input int coarse_w);
    return coarse_w + FINE_W;
  endfunction

endpackage

// File: rtl/tof_fine_encoder.sv
// Delay-line thermometer to fine code: popcount of the tap vector,
// clamped to the largest value a FINE_W-bit code can hold.
module tof_fine_encoder
  import tof_pkg::*;
#(
  parameter int TAPS = 8
) (
  input  logic [TAPS-1:0]   taps,
  output logic [FINE_W-1:0] fine
);

  logic [31:0] ones;

  // Count asserted taps, then saturate to the fine-code range.
  always_comb begin
    ones = '0;
    for (int i = 0; i < TAPS; i++) begin
      ones = ones + {31'd0, taps[i]};
    end
    fine = (ones > 32'd7) ? {FINE_W{1'b1}} : ones[FINE_W-1:0];
  end

endmodule

// File: rtl/tof_shot_sequencer.sv
// Time-of-flight shot sequencer: fires trigger pulses, times the returning
// edge as {coarse cycles, fine tap code}, and accumulates per-run results.
// Optional build macro TOF_MINMAX_EN adds min_time / max_time outputs.
module tof_shot_sequencer
  import tof_pkg::*;
#(
  parameter int COARSE_W = 16,
  parameter int TAPS     = 8,
  parameter int SHOTS_W  = 8,
  parameter int PW_W     = 8,
  parameter int ACC_W    = COARSE_W + FINE_W + SHOTS_W,
  localparam int ST_W    = shot_time_w(COARSE_W)
) (
  input  logic                io_mainClk,
  input  logic                io_reset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [SHOTS_W-1:0]  cfg_shots,
  input  logic [PW_W-1:0]     cfg_pulse_len,
  input  logic [PW_W-1:0]     cfg_holdoff,
  input  logic [COARSE_W-1:0] cfg_timeout,
  output logic                trig_out,
  input  logic                trig_in,
  input  logic [TAPS-1:0]     tap_in,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    acc_sum,
  output logic [SHOTS_W-1:0]  hit_count,
  output logic [SHOTS_W-1:0]  miss_count,
  output logic [ST_W-1:0]     last_time
`ifdef TOF_MINMAX_EN
  ,
  output logic [ST_W-1:0]     min_time,
  output logic [ST_W-1:0]     max_time
`endif
);

  logic              s0_reg, s1_reg, s2_reg;
  logic [TAPS-1:0]   tap0_reg, tap1_reg;
  logic              stop;
  logic [FINE_W-1:0] fine;

  tof_state_t           state_reg;
  logic [COARSE_W-1:0]  coarse_reg;
  logic [COARSE_W-1:0]  coarse_next;
  logic [PW_W-1:0]      pulse_cnt_reg;
  logic [PW_W-1:0]      hold_cnt_reg;
  logic [SHOTS_W-1:0]   shot_idx_reg;
  logic [ST_W-1:0]      shot_time_reg;

  // Return-edge synchroniser; taps travel in lockstep so tap1 pairs with s1.
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      tap0_reg <= '0;
      tap1_reg <= '0;
    end else begin
      s0_reg   <= trig_in;
      s1_reg   <= s0_reg;
      s2_reg   <= s1_reg;
      tap0_reg <= tap_in;
      tap1_reg <= tap0_reg;
    end
  end

  assign stop = s1_reg & ~s2_reg;

  tof_fine_encoder #(.TAPS(TAPS)) u_fine (
    .taps (tap1_reg),
    .fine (fine)
  );

  // Coarse counter saturates rather than wrapping.
  assign coarse_next = (&coarse_reg) ? coarse_reg : coarse_reg + COARSE_W'(1);

  // Shot sequencing FSM with registered outputs and result accumulation.
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      state_reg     <= IDLE;
      coarse_reg    <= '0;
      pulse_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
      shot_idx_reg  <= '0;
      shot_time_reg <= '0;
      trig_out      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      acc_sum       <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      last_time     <= '0;
`ifdef TOF_MINMAX_EN
      min_time      <= '0;
      max_time      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cfg_abort && (state_reg != IDLE)) begin
        // Abort leaves partial results in place for software to read.
        state_reg <= IDLE;
        trig_out  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cfg_start) begin
              acc_sum      <= '0;
              hit_count    <= '0;
              miss_count   <= '0;
              last_time    <= '0;
              shot_idx_reg <= '0;
`ifdef TOF_MINMAX_EN
              min_time     <= '1;
              max_time     <= '0;
`endif
              if (cfg_shots == '0) begin
                state_reg <= DONE;
                done      <= 1'b1;
              end else begin
                state_reg     <= FIRE;
                busy          <= 1'b1;
                trig_out      <= 1'b1;
                coarse_reg    <= '0;
                pulse_cnt_reg <= PW_W'(1);
              end
            end
          end
          FIRE: begin
            coarse_reg <= coarse_next;
            if (stop) begin
              state_reg     <= HIT;
              trig_out      <= 1'b0;
              shot_time_reg <= {coarse_reg, fine};
            end else if (pulse_cnt_reg >= cfg_pulse_len) begin
              // Counter starts at 1, so a zero length still gives one cycle.
              state_reg <= WAIT;
              trig_out  <= 1'b0;
            end else begin
              pulse_cnt_reg <= pulse_cnt_reg + PW_W'(1);
            end
          end
          WAIT: begin
            coarse_reg <= coarse_next;
            if (stop) begin
              state_reg     <= HIT;
              shot_time_reg <= {coarse_reg, fine};
            end else if (coarse_reg >= cfg_timeout) begin
              // >= also catches a timeout already passed during a long pulse.
              state_reg <= MISS;
            end
          end
          HIT: begin
            acc_sum      <= acc_sum + ACC_W'(shot_time_reg);
            hit_count    <= hit_count + SHOTS_W'(1);
            last_time    <= shot_time_reg;
`ifdef TOF_MINMAX_EN
            if (shot_time_reg < min_time) min_time <= shot_time_reg;
            if (shot_time_reg > max_time) max_time <= shot_time_reg;
`endif
            hold_cnt_reg <= '0;
            state_reg    <= HOLDOFF;
          end
          MISS: begin
            miss_count   <= miss_count + SHOTS_W'(1);
            hold_cnt_reg <= '0;
            state_reg    <= HOLDOFF;
          end
          HOLDOFF: begin
            // Stop events are deliberately not looked at here.
            if (hold_cnt_reg >= cfg_holdoff) begin
              if (shot_idx_reg != (cfg_shots - SHOTS_W'(1))) begin
                shot_idx_reg  <= shot_idx_reg + SHOTS_W'(1);
                state_reg     <= FIRE;
                trig_out      <= 1'b1;
                coarse_reg    <= '0;
                pulse_cnt_reg <= PW_W'(1);
              end else begin
                state_reg <= DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg + PW_W'(1);
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tof_shot_sequencer.sv
// Directed bench for tof_shot_sequencer: a table of whole-run vectors plus
// hand-written control sequences. A reflector process answers each trigger
// pulse with a return edge D cycles later, giving coarse = D + 2.
module tb_tof_shot_sequencer;

  localparam int ST_W  = 19;
  localparam int ACC_W = 27;

  logic        clk = 1'b0;
  logic        io_reset;
  logic        cfg_start;
  logic        cfg_abort;
  logic [7:0]  cfg_shots;
  logic [7:0]  cfg_pulse_len;
  logic [7:0]  cfg_holdoff;
  logic [15:0] cfg_timeout;
  logic        trig_out;
  logic        trig_in;
  logic [7:0]  tap_in;
  logic        busy;
  logic        done;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;
  logic [ST_W-1:0] last_time;
`ifdef TOF_MINMAX_EN
  logic [ST_W-1:0] min_time;
  logic [ST_W-1:0] max_time;
`endif

  logic        man_trig = 1'b0;
  logic        refl_trig = 1'b0;
  logic [7:0]  refl_tap = 8'h00;
  logic        prev_trig = 1'b0;
  int          cyc = 0;
  int          raise_at = -1000;
  int          shot_seen = 0;
  int          trig_cyc = 0;
  int          done_cnt = 0;
  logic [3:0]  echo_mask = 4'b0000;
  int          delay_tab [4];
  logic [7:0]  tap_tab [4];

  int n_checks = 0;
  int n_errors = 0;

  assign trig_in = man_trig | refl_trig;
  assign tap_in  = refl_tap;

  always #5 clk = ~clk;

  tof_shot_sequencer dut (
    .io_mainClk    (clk),
    .io_reset      (io_reset),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_shots     (cfg_shots),
    .cfg_pulse_len (cfg_pulse_len),
    .cfg_holdoff   (cfg_holdoff),
    .cfg_timeout   (cfg_timeout),
    .trig_out      (trig_out),
    .trig_in       (trig_in),
    .tap_in        (tap_in),
    .busy          (busy),
    .done          (done),
    .acc_sum       (acc_sum),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .last_time     (last_time)
`ifdef TOF_MINMAX_EN
    ,
    .min_time      (min_time),
    .max_time      (max_time)
`endif
  );

  // Reflector and pulse monitors, all on the falling edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_trig <= trig_out;
    if (trig_out) trig_cyc <= trig_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (!busy) begin
      shot_seen <= 0;
      refl_trig <= 1'b0;
      raise_at  <= -1000;
    end else begin
      if (trig_out && !prev_trig) begin
        shot_seen <= shot_seen + 1;
        if (shot_seen < 4 && echo_mask[shot_seen[1:0]]) begin
          refl_tap <= tap_tab[shot_seen[1:0]];
          raise_at <= cyc + delay_tab[shot_seen[1:0]];
          if (delay_tab[shot_seen[1:0]] == 0) refl_trig <= 1'b1;
        end
      end
      if (cyc == raise_at) refl_trig <= 1'b1;
      if (cyc == raise_at + 3) refl_trig <= 1'b0;
    end
  end

  typedef struct {
    int         shots, pl, ho, to, dly;
    logic [3:0] mask;
    logic [7:0] tap;
    int         e_hit, e_miss, e_acc, e_last, e_trig;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int shots, input int pl, input int ho, input int to);
    cfg_shots     = 8'(shots);
    cfg_pulse_len = 8'(pl);
    cfg_holdoff   = 8'(ho);
    cfg_timeout   = 16'(to);
  endtask

  task automatic set_refl(input logic [3:0] mask, input int dly, input logic [7:0] tap);
    echo_mask = mask;
    for (int k = 0; k < 4; k++) begin
      delay_tab[k] = dly;
      tap_tab[k]   = tap;
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t0, d0;
    set_cfg(v.shots, v.pl, v.ho, v.to);
    set_refl(v.mask, v.dly, v.tap);
    t0 = trig_cyc;
    d0 = done_cnt;
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", idx), busy, (v.shots != 0) ? 1 : 0);
    chk($sformatf("v%0d_done_after_start", idx), done, (v.shots == 0) ? 1 : 0);
    if (v.shots != 0) wait_done($sformatf("v%0d_done_seen", idx), 2000);
    tick();
    chk($sformatf("v%0d_busy_end", idx), busy, 0);
    chk($sformatf("v%0d_done_one_cycle", idx), done, 0);
    chk($sformatf("v%0d_hit", idx), hit_count, v.e_hit);
    chk($sformatf("v%0d_miss", idx), miss_count, v.e_miss);
    chk($sformatf("v%0d_acc", idx), acc_sum, v.e_acc);
    chk($sformatf("v%0d_last", idx), last_time, v.e_last);
    chk($sformatf("v%0d_trig_cycles", idx), trig_cyc - t0, v.e_trig);
    chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
  endtask

  initial begin
    int t0, d0;
    //            shots pl ho  to  dly mask     tap    hit miss acc  last trig
    vecs[0] = '{1, 4,  0, 100, 18, 4'b0001, 8'h07, 1, 0, 163, 163, 4};   // single hit, fine 3
    vecs[1] = '{3, 2,  1, 10,  0,  4'b0000, 8'h00, 0, 3, 0,   0,   6};   // all time out
    vecs[2] = '{1, 1,  0, 50,  5,  4'b0001, 8'hFF, 1, 0, 63,  63,  1};   // full taps -> fine 7
    vecs[3] = '{2, 0,  2, 20,  3,  4'b0011, 8'h01, 2, 0, 82,  41,  2};   // pulse_len 0 acts as 1
    vecs[4] = '{1, 10, 0, 100, 2,  4'b0001, 8'h0F, 1, 0, 36,  36,  5};   // stop during FIRE
    vecs[5] = '{1, 1,  0, 10,  8,  4'b0001, 8'h03, 1, 0, 82,  82,  1};   // stop on coarse==timeout
    vecs[6] = '{0, 4,  0, 100, 0,  4'b0000, 8'h00, 0, 0, 0,   0,   0};   // zero shots clears results
    vecs[7] = '{4, 3,  4, 15,  6,  4'b0101, 8'h07, 2, 2, 134, 67,  12};  // mixed hits and misses
    vecs[8] = '{3, 2,  0, 40,  30, 4'b0111, 8'h3F, 3, 0, 786, 262, 6};   // longer flight, fine 6

    io_reset  = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    set_refl(4'b0000, 0, 8'h00);
    repeat (3) tick();
    io_reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_out", trig_out, 0);
    chk("rst_acc", acc_sum, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_last", last_time, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Start while busy is ignored: no restart, no extra trigger cycles.
    set_cfg(2, 2, 0, 30);
    set_refl(4'b0011, 4, 8'h07);
    t0 = trig_cyc;
    d0 = done_cnt;
    pulse_start();
    repeat (5) tick();
    pulse_start();
    wait_done("busy_start_done", 500);
    tick();
    chk("busy_start_hit", hit_count, 2);
    chk("busy_start_acc", acc_sum, 102);
    chk("busy_start_trig_cycles", trig_cyc - t0, 4);
    chk("busy_start_done_pulses", done_cnt - d0, 1);

    // Late echo during a long holdoff is not counted.
    set_cfg(2, 1, 10, 12);
    set_refl(4'b0001, 4, 8'h07);
    pulse_start();
    repeat (9) tick();
    man_trig = 1'b1;
    repeat (2) tick();
    man_trig = 1'b0;
    wait_done("late_echo_done", 500);
    tick();
    chk("late_echo_hit", hit_count, 1);
    chk("late_echo_miss", miss_count, 1);
    chk("late_echo_acc", acc_sum, 51);
    chk("late_echo_last", last_time, 51);

    // Abort in WAIT of the second shot: idle next cycle, results kept, no done.
    set_cfg(3, 2, 0, 200);
    set_refl(4'b0001, 4, 8'h07);
    t0 = trig_cyc;
    d0 = done_cnt;
    pulse_start();
    repeat (15) tick();
    chk("abort_pre_busy", busy, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_trig_out", trig_out, 0);
    chk("abort_done", done, 0);
    chk("abort_hit_kept", hit_count, 1);
    chk("abort_acc_kept", acc_sum, 51);
    repeat (20) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_trig_cycles", trig_cyc - t0, 4);
    chk("abort_still_idle", busy, 0);

    // Start and abort together in IDLE: start wins.
    set_cfg(1, 1, 0, 50);
    set_refl(4'b0001, 2, 8'h07);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_busy", busy, 1);
    wait_done("start_abort_done", 500);
    tick();
    chk("start_abort_hit", hit_count, 1);
    chk("start_abort_last", last_time, 35);

    // Reset during the second shot's FIRE clears everything next cycle.
    set_cfg(2, 20, 0, 100);
    set_refl(4'b0001, 4, 8'h07);
    pulse_start();
    repeat (11) tick();
    chk("rst_fire_pre_trig", trig_out, 1);
    chk("rst_fire_pre_hit", hit_count, 1);
    io_reset = 1'b1;
    tick();
    chk("rst_fire_trig_out", trig_out, 0);
    chk("rst_fire_busy", busy, 0);
    chk("rst_fire_hit", hit_count, 0);
    chk("rst_fire_acc", acc_sum, 0);
    chk("rst_fire_last", last_time, 0);
    io_reset = 1'b0;
    tick();

`ifdef TOF_MINMAX_EN
    // Three hits with times 40, 17 and 63.
    set_cfg(3, 1, 0, 50);
    echo_mask = 4'b0111;
    delay_tab = '{3, 0, 5, 0};
    tap_tab   = '{8'h00, 8'h01, 8'hFF, 8'h00};
    pulse_start();
    wait_done("minmax_done", 500);
    tick();
    chk("minmax_min", min_time, 17);
    chk("minmax_max", max_time, 63);
    chk("minmax_acc", acc_sum, 120);
    // No hits: min stays all-ones.
    set_cfg(1, 1, 0, 5);
    set_refl(4'b0000, 0, 8'h00);
    pulse_start();
    wait_done("minmax_nohit_done", 500);
    tick();
    chk("minmax_nohit_min", min_time, 19'h7FFFF);
    chk("minmax_nohit_max", max_time, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no summary expected summary before time limit");
    $fatal(1, "watchdog");
  end

endmodule
